// File: rtl/data_mem_arbiter_if.sv
// Bundle of the requester and Data_Memory signals around data_mem_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: both requesters plus the memory read-data return.
interface data_mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata0;
  logic [DATA_WIDTH-1:0] wdata1;

  logic                  gnt0;
  logic                  gnt1;
  logic                  done0;
  logic                  done1;
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1;
  logic                  busy;

  logic                  mem_write_o;
  logic                  mem_read_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata_i,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata_i,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
           mem_write_o, mem_read_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port Data_Memory between the core
// load/store path (port 0) and the loader/debug path (port 1).
// A grant is given combinationally in IDLE. The request is latched at the
// clock edge and the access is held for MEM_LATENCY cycles in ACCESS. A
// one-cycle done pulse follows in DONE.
// Build option: define ARB_ROUND_ROBIN_EN to alternate ties between the
// ports. Without it, port 0 always wins a tie.
module data_mem_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  // Reject latencies the 4-bit cycle counter cannot represent.
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("data_mem_arbiter: MEM_LATENCY must be in 1..15");
  end

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  grant0;
  logic                  grant1;

  // Pick a winner while idle. Reset forces the grants low so that every output is 0 during reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (bus.req0 && bus.req1) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (last_owner_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
`else
        grant0 = 1'b1;
`endif
      end else if (bus.req0) begin
        grant0 = 1'b1;
      end else if (bus.req1) begin
        grant1 = 1'b1;
      end
    end
  end

  // Next-state logic: latch the winning request, count the access down, then signal done.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          we_d    = grant1 ? bus.we1    : bus.we0;
          addr_d  = grant1 ? bus.addr1  : bus.addr0;
          wdata_d = grant1 ? bus.wdata1 : bus.wdata0;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q) begin
              rdata1_d = bus.mem_rdata_i;
            end else begin
              rdata0_d = bus.mem_rdata_i;
            end
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Drive the requesters and the memory. The write strobe fires only in the first ACCESS cycle.
  always_comb begin
    bus.gnt0        = grant0;
    bus.gnt1        = grant1;
    bus.done0       = (state_q == DONE) && !owner_q;
    bus.done1       = (state_q == DONE) && owner_q;
    bus.rdata0      = rdata0_q;
    bus.rdata1      = rdata1_q;
    bus.busy        = (state_q != IDLE);
    bus.mem_read_o  = 1'b0;
    bus.mem_write_o = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (state_q == ACCESS) begin
      bus.mem_read_o  = !we_q;
      bus.mem_write_o = we_q && (cnt_q == CNT_INIT);
      bus.mem_addr_o  = addr_q;
      bus.mem_wdata_o = wdata_q;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter.
// Two instances are built: one with MEM_LATENCY=2 for most scenarios and one
// with MEM_LATENCY=1 for the back-to-back case. Each instance has its own
// small word-addressed memory model. The observed control vector is
// {gnt0, gnt1, done0, done1, busy, mem_read_o, mem_write_o}.
module tb_data_mem_arbiter;

  logic clk;
  logic reset;
  logic memInit;
  int   checks;
  int   failures;
  int   writeCount2;
  int   writeCount1;

  logic [31:0] mem2 [0:63];
  logic [31:0] mem1 [0:63];

  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();
  data_mem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  data_mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational memory read for both instances.
  assign bus2.mem_rdata_i = mem2[bus2.mem_addr_o[7:2]];
  assign bus1.mem_rdata_i = mem1[bus1.mem_addr_o[7:2]];

  // Memory model for the latency-2 instance: preload pattern, then clocked writes.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 64; i++) mem2[i] <= 32'hA5A5_0000 | i;
      mem2[4]     <= 32'hCAFE_F00D;
      writeCount2 <= 0;
    end else if (bus2.mem_write_o) begin
      mem2[bus2.mem_addr_o[7:2]] <= bus2.mem_wdata_o;
      writeCount2                <= writeCount2 + 1;
    end
  end

  // Memory model for the latency-1 instance.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'hA5A5_0000 | i;
      writeCount1 <= 0;
    end else if (bus1.mem_write_o) begin
      mem1[bus1.mem_addr_o[7:2]] <= bus1.mem_wdata_o;
      writeCount1                <= writeCount1 + 1;
    end
  end

  function automatic logic [6:0] obs2();
    return {bus2.gnt0, bus2.gnt1, bus2.done0, bus2.done1,
            bus2.busy, bus2.mem_read_o, bus2.mem_write_o};
  endfunction

  function automatic logic [6:0] obs1();
    return {bus1.gnt0, bus1.gnt1, bus1.done0, bus1.done1,
            bus1.busy, bus1.mem_read_o, bus1.mem_write_o};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusIdle();
    bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.we0 = 1'b0; bus2.we1 = 1'b0;
    bus2.addr0 = '0; bus2.addr1 = '0; bus2.wdata0 = '0; bus2.wdata1 = '0;
    bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.we0 = 1'b0; bus1.we1 = 1'b0;
    bus1.addr0 = '0; bus1.addr1 = '0; bus1.wdata0 = '0; bus1.wdata1 = '0;
  endtask

  // Reset values, including grants held low while reset is high.
  task automatic test_reset();
    reset   = 1'b1;
    memInit = 1'b1;
    applyStimulusIdle();
    bus2.req0 = 1'b1;
    bus1.req0 = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checks++;
    if (obs2() !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctl2 got=%b exp=%b", obs2(), 7'b0);
    end
    checks++;
    if (obs1() !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctl1 got=%b exp=%b", obs1(), 7'b0);
    end
    checks++;
    if ({bus2.rdata0, bus2.rdata1, bus2.mem_addr_o, bus2.mem_wdata_o} !== 128'b0) begin
      failures++;
      $display("[TB] FAIL reset_data got=%h exp=0",
               {bus2.rdata0, bus2.rdata1, bus2.mem_addr_o, bus2.mem_wdata_o});
    end
    nextCycle();
    reset   = 1'b0;
    memInit = 1'b0;
    applyStimulusIdle();
    @(negedge clk);
    checks++;
    if (obs2() !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_release got=%b exp=%b", obs2(), 7'b0);
    end
    nextCycle();
  endtask

  // Port 0 read of 0x10 with MEM_LATENCY=2. The request is dropped right after the grant.
  task automatic test_read();
    logic [6:0] expv [0:4] = '{7'b1000000, 7'b0000110, 7'b0000110, 7'b0010100, 7'b0000000};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        bus2.req0 = 1'b1; bus2.we0 = 1'b0; bus2.addr0 = 32'h10;
      end else begin
        bus2.req0 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs2() !== expv[c]) begin
        failures++;
        $display("[TB] FAIL read_ctl c%0d got=%b exp=%b", c, obs2(), expv[c]);
      end
      if (c == 1) begin
        checks++;
        if (bus2.mem_addr_o !== 32'h10) begin
          failures++;
          $display("[TB] FAIL read_addr got=%h exp=%h", bus2.mem_addr_o, 32'h10);
        end
      end
      if (c >= 3) begin
        checks++;
        if (bus2.rdata0 !== 32'hCAFE_F00D) begin
          failures++;
          $display("[TB] FAIL read_data c%0d got=%h exp=%h", c, bus2.rdata0, 32'hCAFE_F00D);
        end
      end
      nextCycle();
    end
  endtask

  // Port 1 write of 0x12345678 to 0x20, then a port 0 read of the same word.
  task automatic test_write();
    logic [6:0] expv [0:4] = '{7'b0100000, 7'b0000101, 7'b0000100, 7'b0001100, 7'b0000000};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        bus2.req1 = 1'b1; bus2.we1 = 1'b1; bus2.addr1 = 32'h20; bus2.wdata1 = 32'h1234_5678;
      end else begin
        bus2.req1 = 1'b0; bus2.we1 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs2() !== expv[c]) begin
        failures++;
        $display("[TB] FAIL write_ctl c%0d got=%b exp=%b", c, obs2(), expv[c]);
      end
      if (c == 1) begin
        checks++;
        if ({bus2.mem_addr_o, bus2.mem_wdata_o} !== {32'h20, 32'h1234_5678}) begin
          failures++;
          $display("[TB] FAIL write_bus got=%h/%h exp=00000020/12345678",
                   bus2.mem_addr_o, bus2.mem_wdata_o);
        end
      end
      if (c >= 3) begin
        checks++;
        if (bus2.rdata1 !== 32'h0) begin
          failures++;
          $display("[TB] FAIL write_rdata1 c%0d got=%h exp=0", c, bus2.rdata1);
        end
      end
      nextCycle();
    end
    checks++;
    if (writeCount2 !== 1) begin
      failures++;
      $display("[TB] FAIL write_count got=%0d exp=1", writeCount2);
    end
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        bus2.req0 = 1'b1; bus2.we0 = 1'b0; bus2.addr0 = 32'h20;
      end else begin
        bus2.req0 = 1'b0;
      end
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if ({bus2.done0, bus2.rdata0} !== {1'b1, 32'h1234_5678}) begin
          failures++;
          $display("[TB] FAIL readback got=%b/%h exp=1/12345678", bus2.done0, bus2.rdata0);
        end
      end
      nextCycle();
    end
  endtask

  // Both ports request continuously for four transactions, starting just after a reset.
  task automatic test_tie();
    logic [3:0] winners;
`ifdef ARB_ROUND_ROBIN_EN
    winners = 4'b1010;
`else
    winners = 4'b0000;
`endif
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bus2.req0 = 1'b1; bus2.we0 = 1'b0; bus2.addr0 = 32'h0;
      bus2.req1 = 1'b1; bus2.we1 = 1'b0; bus2.addr1 = 32'h4;
      @(negedge clk);
      checks++;
      if ({bus2.gnt0, bus2.gnt1} !== (winners[t] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("[TB] FAIL tie_gnt t%0d got=%b exp=%b", t, {bus2.gnt0, bus2.gnt1},
                 winners[t] ? 2'b01 : 2'b10);
      end
      nextCycle();
      nextCycle();
      nextCycle();
      @(negedge clk);
      checks++;
      if ({bus2.done0, bus2.done1} !== (winners[t] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("[TB] FAIL tie_done t%0d got=%b exp=%b", t, {bus2.done0, bus2.done1},
                 winners[t] ? 2'b01 : 2'b10);
      end
      nextCycle();
    end
    bus2.req0 = 1'b0;
    bus2.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs2() !== 7'b0) begin
      failures++;
      $display("[TB] FAIL tie_idle got=%b exp=%b", obs2(), 7'b0);
    end
    checks++;
    if (bus2.rdata1 !== (winners[1] ? 32'hA5A5_0001 : 32'h0)) begin
      failures++;
      $display("[TB] FAIL tie_rdata1 got=%h exp=%h", bus2.rdata1,
               winners[1] ? 32'hA5A5_0001 : 32'h0);
    end
    nextCycle();
  endtask

  // Reset during the second ACCESS cycle of a read, with req0 held throughout.
  task automatic test_reset_abort();
    bus2.req0 = 1'b1; bus2.we0 = 1'b0; bus2.addr0 = 32'h10;
    @(negedge clk);
    checks++;
    if (obs2() !== 7'b1000000) begin
      failures++;
      $display("[TB] FAIL abort_gnt got=%b exp=%b", obs2(), 7'b1000000);
    end
    nextCycle();
    nextCycle();
    checks++;
    if (obs2() !== 7'b0000110) begin
      failures++;
      $display("[TB] FAIL abort_access got=%b exp=%b", obs2(), 7'b0000110);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({obs2(), bus2.mem_addr_o, bus2.rdata0} !== 71'b0) begin
      failures++;
      $display("[TB] FAIL abort_async got=%b/%h/%h exp=0", obs2(), bus2.mem_addr_o, bus2.rdata0);
    end
    nextCycle();
    @(negedge clk);
    checks++;
    if (obs2() !== 7'b0) begin
      failures++;
      $display("[TB] FAIL abort_nodone got=%b exp=%b", obs2(), 7'b0);
    end
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs2() !== 7'b1000000) begin
      failures++;
      $display("[TB] FAIL abort_regrant got=%b exp=%b", obs2(), 7'b1000000);
    end
    nextCycle();
    bus2.req0 = 1'b0;
    nextCycle();
    nextCycle();
    @(negedge clk);
    checks++;
    if ({obs2(), bus2.rdata0} !== {7'b0010100, 32'hCAFE_F00D}) begin
      failures++;
      $display("[TB] FAIL abort_redo got=%b/%h exp=%b/%h", obs2(), bus2.rdata0,
               7'b0010100, 32'hCAFE_F00D);
    end
    nextCycle();
  endtask

  // MEM_LATENCY=1 instance: reads of 0x0 then 0x4 with req0 held across both.
  task automatic test_back_to_back();
    logic [6:0] expv [0:6] = '{7'b1000000, 7'b0000110, 7'b0010100, 7'b1000000,
                               7'b0000110, 7'b0010100, 7'b0000000};
    for (int c = 0; c < 7; c++) begin
      if (c == 0) begin
        bus1.req0 = 1'b1; bus1.we0 = 1'b0; bus1.addr0 = 32'h0;
      end else if (c == 1) begin
        bus1.addr0 = 32'h4;
      end else if (c == 5) begin
        bus1.req0 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs1() !== expv[c]) begin
        failures++;
        $display("[TB] FAIL b2b_ctl c%0d got=%b exp=%b", c, obs1(), expv[c]);
      end
      if (c == 2 || c == 5) begin
        checks++;
        if (bus1.rdata0 !== ((c == 2) ? 32'hA5A5_0000 : 32'hA5A5_0001)) begin
          failures++;
          $display("[TB] FAIL b2b_data c%0d got=%h exp=%h", c, bus1.rdata0,
                   (c == 2) ? 32'hA5A5_0000 : 32'hA5A5_0001);
        end
      end
      nextCycle();
    end
  endtask

  // A one-cycle port 1 write request while port 0 is being served must be ignored.
  task automatic test_ignored_req();
    logic [6:0] expv [0:4] = '{7'b1000000, 7'b0000110, 7'b0000110, 7'b0010100, 7'b0000000};
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        bus2.req0 = 1'b1; bus2.we0 = 1'b0; bus2.addr0 = 32'h8;
      end else if (c == 1) begin
        bus2.req0 = 1'b0;
        bus2.req1 = 1'b1; bus2.we1 = 1'b1; bus2.addr1 = 32'h30; bus2.wdata1 = 32'hDEAD_BEEF;
      end else begin
        bus2.req1 = 1'b0; bus2.we1 = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (obs2() !== expv[c]) begin
        failures++;
        $display("[TB] FAIL ignore_ctl c%0d got=%b exp=%b", c, obs2(), expv[c]);
      end
      if (c == 3) begin
        checks++;
        if (bus2.rdata0 !== 32'hA5A5_0002) begin
          failures++;
          $display("[TB] FAIL ignore_rdata0 got=%h exp=%h", bus2.rdata0, 32'hA5A5_0002);
        end
      end
      nextCycle();
    end
    checks++;
    if ({mem2[12], bus2.rdata1} !== {32'hA5A5_000C, 32'h0}) begin
      failures++;
      $display("[TB] FAIL ignore_mem got=%h/%h exp=a5a5000c/00000000", mem2[12], bus2.rdata1);
    end
    checks++;
    if (writeCount2 !== 1) begin
      failures++;
      $display("[TB] FAIL ignore_wcount got=%0d exp=1", writeCount2);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_reset_abort();
    test_back_to_back();
    test_ignored_req();
    checks++;
    if (writeCount1 !== 0) begin
      failures++;
      $display("[TB] FAIL lat1_wcount got=%0d exp=0", writeCount1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
